// File: rtl/buffer_uart_tx_if.sv
// rtl/buffer_uart_tx_if.sv - FIFO drain handshake between the word FIFO and buffer_uart_tx
//
// Signals:
//   word_in        FIFO data_out; stable while word_in_valid=1
//   word_in_valid  FIFO data_out_valid; a word is available
//   word_in_read   FIFO data_out_read; one-cycle pop strobe from the consumer
// Modports:
//   master  FIFO side (drives word and valid, receives the pop strobe)
//   slave   consumer side (buffer_uart_tx)

interface buffer_uart_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] word_in;
    logic                  word_in_valid;
    logic                  word_in_read;

    modport master (
        output word_in,
        output word_in_valid,
        input  word_in_read
    );

    modport slave (
        input  word_in,
        input  word_in_valid,
        output word_in_read
    );
endinterface

// File: rtl/buffer_uart_tx.sv
// rtl/buffer_uart_tx.sv - pops 32-bit FIFO words and serializes them as 8N1 UART bytes, MSB byte first
//
// Parameters:
//   DATA_WIDTH      word width, multiple of 8
//   CLKS_PER_BIT    clk cycles per UART bit, >= 2
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   slave side of buffer_uart_tx_if (word_in, word_in_valid in; word_in_read out)
//   tx    registered UART line, idles high
//   busy  high whenever a word is being sent

module buffer_uart_tx #(
    parameter  int DATA_WIDTH     = 32,
    parameter  int CLKS_PER_BIT   = 868,
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    buffer_uart_tx_if.slave   bus,
    output logic              tx,
    output logic              busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BAUD_W-1:0]     baud_q,  baud_d;
    logic [2:0]            bit_q,   bit_d;
    logic [BYTE_W-1:0]     byte_q,  byte_d;
    logic                  read_q,  read_d;
    logic                  tx_q,    tx_d;
    logic [7:0]            byte_sel_d;
    logic                  baud_done;

    assign baud_done = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            read_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            read_q  <= read_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic. The pop strobe can only be raised from IDLE, and IDLE
    // is always left on the same edge, so it can never stay high two cycles.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        read_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.word_in_valid) begin
                    state_d = S_START;
                    shift_d = bus.word_in;
                    read_d  = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q != BYTE_LAST) begin
                        // Next byte of the same word follows with no idle gap.
                        shift_d = shift_q << 8;
                        byte_d  = byte_q + 1'b1;
                        bit_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // tx is registered: it is decoded from the next state so the line level
    // lines up with the state the FSM is entering.
    always_comb begin
        byte_sel_d = shift_d[DATA_WIDTH-1 -: 8];
        tx_d       = 1'b1;
        case (state_d)
            S_IDLE:  tx_d = 1'b1;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = byte_sel_d[bit_d];
            S_STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.word_in_read = read_q;
    assign tx               = tx_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_buffer_uart_tx.sv
// tb/tb_buffer_uart_tx.sv - scoreboard bench for buffer_uart_tx with FIFO model and UART decoder

module tb_buffer_uart_tx;

    localparam int DW  = 32;
    localparam int CPB = 10;
    localparam int WORD_CYCLES = 4 * 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;

    buffer_uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    buffer_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [DW-1:0] fifo[$];
    logic [7:0]    exp_q[$];
    int            read_cycles[$];
    int            read_count = 0;

    logic          ovr_en    = 1'b0;
    logic [DW-1:0] ovr_word  = '0;
    logic          ovr_valid = 1'b0;
    logic          valid_at_edge = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Behavioural FIFO: pops on any edge where the consumer's strobe is high;
    // a popped word becomes four expected bytes, MSB first.
    initial begin
        bus.word_in       = '0;
        bus.word_in_valid = 1'b0;
        forever begin
            @(posedge clk);
            valid_at_edge = bus.word_in_valid;
            if (bus.word_in_read === 1'b1 && fifo.size() > 0) begin
                logic [DW-1:0] w;
                w = fifo.pop_front();
                for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
            end
            #1;
            if (ovr_en) begin
                bus.word_in       = ovr_word;
                bus.word_in_valid = ovr_valid;
            end else if (fifo.size() > 0) begin
                bus.word_in       = fifo[0];
                bus.word_in_valid = 1'b1;
            end else begin
                bus.word_in       = $urandom;
                bus.word_in_valid = 1'b0;
            end
        end
    end

    // Handshake / busy / idle-line monitor.
    logic prev_read  = 1'b0;
    logic prev_busy  = 1'b0;
    logic busy_abort = 1'b0;
    int   busy_start = 0;

    always @(negedge clk) begin
        if (rst === 1'b1) busy_abort = 1'b1;
        if (bus.word_in_read === 1'b1) begin
            check("read_tx_start_bit", tx, 1'b0);
            check("read_busy", busy, 1'b1);
            check("read_width", prev_read, 1'b0);
            check("read_needs_valid", valid_at_edge, 1'b1);
            read_count++;
            read_cycles.push_back(cyc);
        end
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            busy_start = cyc;
            busy_abort = 1'b0;
        end
        if (busy === 1'b0 && prev_busy === 1'b1 && !busy_abort)
            check("busy_len", 64'(cyc - busy_start), 64'(WORD_CYCLES));
        if (busy === 1'b0 && rst === 1'b0)
            check("idle_tx_high", tx, 1'b1);
        prev_read = bus.word_in_read;
        prev_busy = busy;
    end

    // UART receiver: samples each bit mid-way, compares every byte with the scoreboard.
    logic       rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                int k;
                k = rx_cnt / CPB;
                if (k == 0) begin
                    check("start_bit", tx, 1'b0);
                end else if (k <= 8) begin
                    rx_byte[k-1] = tx;
                end else begin
                    check("stop_bit", tx, 1'b1);
                    if (exp_q.size() == 0) begin
                        check("byte_unexpected", 64'(rx_byte), 64'hFFFF_FFFF);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("byte", rx_byte, e);
                    end
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!(fifo.size() == 0 && exp_q.size() == 0 && busy === 1'b0 && !rx_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check({name, "_timeout"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_read(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.word_in_read !== 1'b1 && n < budget);
        if (bus.word_in_read !== 1'b1) check({name, "_timeout"}, 64'(bus.word_in_read), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int bad;

        // Reset held 3 edges with a word already waiting, then single word A1B2C3D4.
        rst = 1'b1;
        fifo.push_back(32'hA1B2_C3D4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx", tx, 1'b1);
            check("rst_read", bus.word_in_read, 1'b0);
            check("rst_busy", busy, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("first_pop_after_rst", bus.word_in_read, 1'b1);
        wait_idle(1000, "single");
        check("single_read_count", 64'(read_count), 64'd1);

        // Back-to-back words: pops exactly one word period plus one idle cycle apart.
        read_cycles.delete();
        fifo.push_back(32'h0000_0001);
        fifo.push_back(32'hFFFF_FFFF);
        wait_idle(2000, "b2b");
        check("b2b_pops", 64'(read_cycles.size()), 64'd2);
        if (read_cycles.size() == 2)
            check("b2b_period", 64'(read_cycles[1] - read_cycles[0]), 64'(WORD_CYCLES + 1));
        rc0 = read_count;
        repeat (50) @(negedge clk);
        check("b2b_no_extra_pop", 64'(read_count), 64'(rc0));

        // Input disturbance during byte 1 must not affect the captured word.
        rc0 = read_count;
        fifo.push_back(32'hDEAD_BEEF);
        wait_read(50, "stab_pop");
        repeat (120) @(negedge clk);
        ovr_en   = 1'b1;
        ovr_word = 32'h1234_5678;
        for (int i = 0; i < 60; i++) begin
            ovr_valid = 1'($urandom);
            @(negedge clk);
        end
        ovr_en = 1'b0;
        wait_idle(1000, "stab");
        check("stab_read_count", 64'(read_count), 64'(rc0 + 1));

        // Reset at cycle 150 of a word: remainder lost, next word clean.
        rc0 = read_count;
        fifo.push_back($urandom);
        wait_read(50, "mid_pop");
        repeat (149) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_read", bus.word_in_read, 1'b0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_pop", 64'(read_count), 64'(rc0 + 1));
        fifo.push_back($urandom);
        wait_idle(1000, "post_rst");
        check("post_rst_pop", 64'(read_count), 64'(rc0 + 2));

        // Empty FIFO: line idle, no pops.
        rc0 = read_count;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.word_in_read !== 1'b0) bad++;
        end
        check("empty_idle_violations", 64'(bad), 64'd0);
        check("empty_no_pop", 64'(read_count), 64'(rc0));

        // Random words with random gaps and occasional bursts.
        rc0 = read_count;
        for (int i = 0; i < 8; i++) begin
            fifo.push_back($urandom);
            if ($urandom_range(0, 3) == 0) fifo.push_back($urandom);
            repeat ($urandom_range(0, 500)) @(negedge clk);
        end
        wait_idle(8000, "random");
        check("random_all_popped", 64'(fifo.size()), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/buffer_uart_tx.md
# buffer_uart_tx

Drain-side consumer for the 32-bit word FIFO: it pops one word at a time through the FIFO's valid/read handshake and serializes it as 8N1 UART frames on a single `tx` line. It sits between the FIFO output (`data_out`, `data_out_valid`, `data_out_read`) and the board UART pin, carrying measurement words to the host PC. Each word goes out as DATA_WIDTH/8 bytes, most-significant byte first, with each byte sent LSB-first.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be ≥ 2.
- BYTES_PER_WORD, DATA_WIDTH/8, derived; not to be overridden.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- word_in  in  DATA_WIDTH  word from the FIFO `data_out`; must be stable while word_in_valid=1.
- word_in_valid  in  1  FIFO `data_out_valid`; a word is available.
- word_in_read  out  1  pop strobe to FIFO `data_out_read`; registered, one-cycle pulse.
- tx  out  1  UART serial output; registered; idle level 1.
- busy  out  1  1 whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: tx=1, busy=0.
  - START: tx=0.
  - DATA: tx=shift[MSB byte][bit_idx].
  - STOP: tx=1.
- Registers:
  - shift: DATA_WIDTH bits, holds the captured word.
  - baud_cnt: $clog2(CLKS_PER_BIT) bits.
  - bit_idx: 3 bits.
  - byte_idx: $clog2(BYTES_PER_WORD) bits, minimum 1 bit.
- IDLE → START on any edge where word_in_valid=1:
  - capture shift<=word_in;
  - word_in_read<=1;
  - clear baud_cnt, bit_idx and byte_idx.
  - Otherwise stay in IDLE, word_in_read<=0.
- Pop and capture happen in the same cycle. The FIFO advances on the edge where word_in_read=1, so word_in may change afterwards; the captured copy is unaffected.
- word_in_read:
  - deasserted on the edge after it rises, so it is never high for 2 cycles;
  - never asserted outside IDLE;
  - never asserted while word_in_valid=0.
- Each bit state lasts exactly CLKS_PER_BIT cycles. baud_cnt counts 0..CLKS_PER_BIT-1; the state or bit advances when baud_cnt==CLKS_PER_BIT-1.
- START → DATA with bit_idx=0.
- DATA:
  - tx = bit bit_idx of the current byte;
  - the current byte is shift[DATA_WIDTH-1 -: 8];
  - after bit 7, go to STOP.
- STOP:
  - if byte_idx < BYTES_PER_WORD-1: shift<<=8, byte_idx+1, go to START (no idle gap between bytes of a word);
  - else go to IDLE.
- word_in_valid is ignored outside IDLE; dropping or toggling it mid-word has no effect.
- FIFO empty: remain in IDLE indefinitely with tx=1.
- Reset mid-operation:
  - the next cycle state=IDLE, tx=1, word_in_read=0, busy=0;
  - the partially sent word is lost, since it was already popped;
  - the line may show a truncated frame, and the host handles the framing error.

## Timing
- Reset values: tx=1, word_in_read=0, busy=0, state=IDLE, all counters 0, shift=0.
- Cycle numbering, with C0 the edge on which IDLE samples word_in_valid=1:
  - C0+1: word_in_read=1, tx=0 (start bit), busy=1.
  - C0+2: word_in_read=0.
- Byte k (0-based) start bit begins at C0+1+k·10·CLKS_PER_BIT.
- Last stop bit ends at C0+1+BYTES_PER_WORD·10·CLKS_PER_BIT; the FSM is in IDLE from that cycle.
- Back-to-back words, with the FIFO non-empty:
  - at least 1 cycle of IDLE (tx=1) between the last stop bit and the next start bit;
  - word period = 10·BYTES_PER_WORD·CLKS_PER_BIT + 1 cycles, i.e. 401 cycles at CLKS_PER_BIT=10.
- Throughput independent of FIFO fill; no combinational path from word_in_valid to word_in_read or tx.

## Test plan
Benches use CLKS_PER_BIT=10, DATA_WIDTH=32, driven by a behavioural FIFO model.

1. Reset: hold rst for 3 cycles with word_in_valid=1 → tx=1, word_in_read=0 and busy=0 during and 1 cycle after reset; first pop only on the first post-reset edge.
2. Single word 0xA1B2C3D4:
   - exactly one word_in_read pulse, 1 cycle wide;
   - tx decodes as bytes A1, B2, C3, D4, each a start 0 + 8 LSB-first bits + stop 1 at 10 cycles/bit;
   - busy falls 400 cycles after the start bit begins.
3. Back-to-back: FIFO preloaded with 0x00000001, 0xFFFFFFFF → read pulses exactly 401 cycles apart; decoded bytes 00 00 00 01 FF FF FF FF; then tx stays 1 and no further pops.
4. Stability: change word_in to 0x12345678 and drop word_in_valid during byte 1 of word 0xDEADBEEF → bytes DE AD BE EF sent unchanged.
5. Reset mid-word: assert rst at cycle 150 of a word → next cycle tx=1, busy=0; no pop until word_in_valid is sampled after rst falls; the following word decodes correctly.
6. Empty FIFO: word_in_valid=0 for 2000 cycles → tx=1 and word_in_read=0 throughout.
